// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU execute slice.
// Contents: ALU opcode and branch-condition encodings, bit positions inside
// the EX/M/WB control bundles, NOP bundle constants, and small decode helpers
// used by ex_slice.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_NAND = 4'h2,
    OP_XOR  = 4'h3,
    OP_SRA  = 4'h5,
    OP_SRL  = 4'h6,
    OP_SLL  = 4'h7,
    OP_LHB  = 4'hA,
    OP_LLB  = 4'hB
  } alu_op_e;

  typedef enum logic [2:0] {
    BC_NE, BC_EQ, BC_GT, BC_LT, BC_GTE, BC_LTE, BC_OVF, BC_UNC
  } bcond_e;

  // EX bundle: {Branch, op15, SPAddr, PCToMem, ALUSrc[1:0], ALUOp[3:0]}
  localparam int EX_W        = 10;
  localparam int EX_BRANCH   = 9;
  localparam int EX_OP15     = 8;
  localparam int EX_SPADDR   = 7;
  localparam int EX_PC2MEM   = 6;
  localparam int EX_ALUSRC   = 4;  // low bit of the 2-bit field
  localparam int EX_ALUOP    = 0;  // low bit of the 4-bit field

  // M bundle: {MemWrite, MemRead}
  localparam int M_W         = 2;
  localparam int M_WRITE     = 1;
  localparam int M_READ      = 0;

  // WB bundle: {dst[3:0], RegWrite, Ret, MemToReg}
  localparam int WB_W        = 7;
  localparam int WB_DST      = 3;  // low bit of the 4-bit field
  localparam int WB_REGWRITE = 2;
  localparam int WB_RET      = 1;
  localparam int WB_MEM2REG  = 0;

  localparam logic [EX_W-1:0] EX_NOP = '0;
  localparam logic [M_W-1:0]  M_NOP  = '0;
  localparam logic [WB_W-1:0] WB_NOP = '0;

  // Which flags an ALU op is allowed to write.
  typedef enum logic [1:0] {FL_ZVN, FL_Z, FL_NONE} flag_cls_e;

  function automatic flag_cls_e flag_cls(input logic [3:0] op);
    case (op)
      OP_NAND, OP_XOR, OP_SRA, OP_SRL, OP_SLL: return FL_Z;
      OP_LHB, OP_LLB:                          return FL_NONE;
      default:                                 return FL_ZVN;  // ADD/SUB and ADD aliases
    endcase
  endfunction

  function automatic logic bcond_met(input logic [2:0] bc, input logic z, v, n);
    case (bc)
      BC_NE:   return !z;
      BC_EQ:   return z;
      BC_GT:   return !z && !n;
      BC_LT:   return n;
      BC_GTE:  return z || !n;
      BC_LTE:  return n || z;
      BC_OVF:  return v;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ex_slice_alu16.sv
// alu16: purely combinational 16-bit ALU of the execute stage.
// Ports: op_a/op_b operands, alu_op opcode -> result plus z/v/n.
// z and n always describe the wrapped (unsaturated) value; v is only ever
// set by ADD/SUB (and the opcodes that alias to ADD).
// Build option: EX_SAT_ARITH_EN makes overflowing ADD/SUB clamp to the most
// positive/negative value instead of wrapping; v is still reported.
module alu16
  import cpu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  input  logic [3:0]    alu_op,
  output logic [DW-1:0] result,
  output logic          z,
  output logic          v,
  output logic          n
);

  logic          sub, ovf, arith;
  logic [DW-1:0] b_eff, sum, raw;

  always_comb begin
    sub   = (alu_op == OP_SUB);
    b_eff = sub ? ~op_b : op_b;
    sum   = op_a + b_eff + DW'(sub);
    // overflow: both addends share a sign and the sum's sign differs
    ovf   = (op_a[DW-1] == b_eff[DW-1]) && (sum[DW-1] != op_a[DW-1]);
    arith = 1'b0;
    case (alu_op)
      OP_NAND: raw = ~(op_a & op_b);
      OP_XOR:  raw = op_a ^ op_b;
      OP_SRA:  raw = DW'($signed(op_a) >>> op_b[3:0]);
      OP_SRL:  raw = op_a >> op_b[3:0];
      OP_SLL:  raw = op_a << op_b[3:0];
      OP_LHB:  raw = DW'({op_b[7:0], op_a[7:0]});
      OP_LLB:  raw = {op_a[DW-1:8], op_b[7:0]};
      default: begin
        raw   = sum;
        arith = 1'b1;
      end
    endcase
    z      = (raw == '0);
    n      = raw[DW-1];
    v      = arith & ovf;
    result = raw;
`ifdef EX_SAT_ARITH_EN
    // on overflow the true result has the sign of op_a
    if (arith && ovf)
      result = op_a[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
  end

endmodule

// File: rtl/ex_slice.sv
// ex_slice: execute stage of the 5-stage 16-bit CPU.
// Holds the ID/EX register, forwards operands from MEM (fm_*) and WB (fw_*),
// runs alu16, keeps the {Z,V,N} flag register and resolves branches.
// Inputs : clk, rst (sync, active high), bubble, id_* decode bundle,
//          fm_* / fw_* forwarding sources.
// Outputs: alu_out, mem_addr, store_data, M_out, WB_out, branch_taken,
//          branch_target, flags {Z,V,N}.
// Build option: EX_SAT_ARITH_EN (saturating ADD/SUB, see alu16).
module ex_slice
  import cpu_pkg::*;
#(
  parameter int DW = 16,
  parameter int RA = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bubble,
  input  logic [EX_W-1:0] id_EX,
  input  logic [M_W-1:0]  id_M,
  input  logic [WB_W-1:0] id_WB,
  input  logic [DW-1:0]   id_r0data,
  input  logic [DW-1:0]   id_r1data,
  input  logic [RA-1:0]   id_src0,
  input  logic [RA-1:0]   id_src1,
  input  logic [DW-1:0]   id_imm,
  input  logic [DW-1:0]   id_offset,
  input  logic [DW-1:0]   id_PC_inc,
  input  logic [DW-1:0]   id_PCbranch,
  input  logic [2:0]      id_bcond,
  input  logic            fm_we,
  input  logic [RA-1:0]   fm_addr,
  input  logic [DW-1:0]   fm_data,
  input  logic            fw_we,
  input  logic [RA-1:0]   fw_addr,
  input  logic [DW-1:0]   fw_data,
  output logic [DW-1:0]   alu_out,
  output logic [DW-1:0]   mem_addr,
  output logic [DW-1:0]   store_data,
  output logic [M_W-1:0]  M_out,
  output logic [WB_W-1:0] WB_out,
  output logic            branch_taken,
  output logic [DW-1:0]   branch_target,
  output logic [2:0]      flags
);

  // ID/EX register
  logic [EX_W-1:0] ex_ctl;
  logic [M_W-1:0]  ex_m;
  logic [WB_W-1:0] ex_wb;
  logic [DW-1:0]   ex_r0, ex_r1, ex_imm, ex_pcinc, ex_pcbr;
  logic [7:0]      ex_off8;  // only the low byte of the offset is ever used
  logic [RA-1:0]   ex_s0, ex_s1;
  logic [2:0]      ex_bc;
  logic            flag_z, flag_v, flag_n;

  logic [DW-1:0]   op_a, fwd_b, op_b;
  logic            alu_z, alu_v, alu_n, flag_wr;

  // MEM beats WB; r0 is hard-wired zero so it is never forwarded.
  always_comb begin
    op_a = ex_r0;
    if (ex_s0 != '0 && fm_we && fm_addr == ex_s0)      op_a = fm_data;
    else if (ex_s0 != '0 && fw_we && fw_addr == ex_s0) op_a = fw_data;
    fwd_b = ex_r1;
    if (ex_s1 != '0 && fm_we && fm_addr == ex_s1)      fwd_b = fm_data;
    else if (ex_s1 != '0 && fw_we && fw_addr == ex_s1) fwd_b = fw_data;
    case (ex_ctl[EX_ALUSRC +: 2])
      2'b00:   op_b = fwd_b;
      2'b01:   op_b = ex_imm;
      2'b10:   op_b = {{(DW-8){1'b0}}, ex_off8};
      default: op_b = DW'(1);
    endcase
  end

  alu16 #(.DW(DW)) u_alu (
    .op_a   (op_a),
    .op_b   (op_b),
    .alu_op (ex_ctl[EX_ALUOP +: 4]),
    .result (alu_out),
    .z      (alu_z),
    .v      (alu_v),
    .n      (alu_n)
  );

  // Only plain register-writing ALU ops touch the flags; a bubble has
  // RegWrite=0 so it never does.
  assign flag_wr = !ex_ctl[EX_BRANCH] && !ex_m[M_WRITE] && !ex_m[M_READ] &&
                   ex_wb[WB_REGWRITE];

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctl   <= EX_NOP;
      ex_m     <= M_NOP;
      ex_wb    <= WB_NOP;
      ex_r0    <= '0;
      ex_r1    <= '0;
      ex_imm   <= '0;
      ex_off8  <= '0;
      ex_pcinc <= '0;
      ex_pcbr  <= '0;
      ex_s0    <= '0;
      ex_s1    <= '0;
      ex_bc    <= '0;
      flag_z   <= 1'b0;
      flag_v   <= 1'b0;
      flag_n   <= 1'b0;
    end else begin
      ex_ctl   <= bubble ? EX_NOP : id_EX;
      ex_m     <= bubble ? M_NOP  : id_M;
      ex_wb    <= bubble ? WB_NOP : id_WB;
      ex_r0    <= id_r0data;
      ex_r1    <= id_r1data;
      ex_imm   <= id_imm;
      ex_off8  <= id_offset[7:0];
      ex_pcinc <= id_PC_inc;
      ex_pcbr  <= id_PCbranch;
      ex_s0    <= id_src0;
      ex_s1    <= id_src1;
      ex_bc    <= id_bcond;
      if (flag_wr) begin
        case (flag_cls(ex_ctl[EX_ALUOP +: 4]))
          FL_ZVN: begin
            flag_z <= alu_z;
            flag_v <= alu_v;
            flag_n <= alu_n;
          end
          FL_Z:    flag_z <= alu_z;
          default: ;
        endcase
      end
    end
  end

  // Call stores at the old SP (SPAddr=1); Ret addresses SP+1 via the ALU.
  assign mem_addr      = ex_ctl[EX_SPADDR] ? op_a : alu_out;
  assign store_data    = ex_ctl[EX_PC2MEM] ? ex_pcinc : fwd_b;
  assign M_out         = ex_m;
  assign WB_out        = ex_wb;
  assign branch_taken  = ex_ctl[EX_BRANCH] && bcond_met(ex_bc, flag_z, flag_v, flag_n);
  assign branch_target = ex_pcbr;
  assign flags         = {flag_z, flag_v, flag_n};

  // op15 is decoded upstream and the offset high byte is never consumed here.
  logic unused_ok;
  assign unused_ok = ^{ex_ctl[EX_OP15], id_offset[DW-1:8]};

endmodule

// File: tb/tb_ex_slice.sv
module tb_ex_slice;

  logic        clk = 1'b0;
  logic        rst, bubble;
  logic [9:0]  id_EX;
  logic [1:0]  id_M;
  logic [6:0]  id_WB;
  logic [15:0] id_r0data, id_r1data, id_imm, id_offset, id_PC_inc, id_PCbranch;
  logic [3:0]  id_src0, id_src1;
  logic [2:0]  id_bcond;
  logic        fm_we, fw_we;
  logic [3:0]  fm_addr, fw_addr;
  logic [15:0] fm_data, fw_data;
  logic [15:0] alu_out, mem_addr, store_data, branch_target;
  logic [1:0]  M_out;
  logic [6:0]  WB_out;
  logic        branch_taken;
  logic [2:0]  flags;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  ex_slice dut (
    .clk(clk), .rst(rst), .bubble(bubble),
    .id_EX(id_EX), .id_M(id_M), .id_WB(id_WB),
    .id_r0data(id_r0data), .id_r1data(id_r1data),
    .id_src0(id_src0), .id_src1(id_src1),
    .id_imm(id_imm), .id_offset(id_offset),
    .id_PC_inc(id_PC_inc), .id_PCbranch(id_PCbranch), .id_bcond(id_bcond),
    .fm_we(fm_we), .fm_addr(fm_addr), .fm_data(fm_data),
    .fw_we(fw_we), .fw_addr(fw_addr), .fw_data(fw_data),
    .alu_out(alu_out), .mem_addr(mem_addr), .store_data(store_data),
    .M_out(M_out), .WB_out(WB_out),
    .branch_taken(branch_taken), .branch_target(branch_target), .flags(flags)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Instruction currently in EX, as the bench issued it.
  logic [9:0]  m_ctl;
  logic [1:0]  m_m;
  logic [6:0]  m_wb;
  logic [15:0] m_r0, m_r1, m_imm, m_off, m_pcinc, m_pcbr;
  logic [3:0]  m_s0, m_s1;
  logic [2:0]  m_bc;
  logic        m_bub;
  logic        mz, mv, mn;

  typedef struct {
    logic [15:0] alu, maddr, sdata;
    logic        taken, z, v, n;
    int          cls;  // 0: Z,V,N written  1: Z only  2: none
  } exp_t;
  exp_t pe, ce;

  function automatic logic [15:0] mfwd(input logic [3:0] s, input logic [15:0] rf);
    if (s != 0 && fm_we && fm_addr == s) return fm_data;
    if (s != 0 && fw_we && fw_addr == s) return fw_data;
    return rf;
  endfunction

  function automatic exp_t calc();
    exp_t e;
    logic [15:0] a, b1, b, wrap;
    logic signed [15:0] sg;
    int sa, sb, full;
    logic ok;
    a  = mfwd(m_s0, m_r0);
    b1 = mfwd(m_s1, m_r1);
    case (m_ctl[5:4])
      2'd0:    b = b1;
      2'd1:    b = m_imm;
      2'd2:    b = {8'h00, m_off[7:0]};
      default: b = 16'h0001;
    endcase
    sa   = $signed(a);
    sb   = $signed(b);
    full = (m_ctl[3:0] == 4'd1) ? sa - sb : sa + sb;
    wrap = full[15:0];
    e.v  = (full > 32767) || (full < -32768);
    e.z  = (wrap == 16'h0000);
    e.n  = wrap[15];
    e.cls = 0;
    e.alu = wrap;
`ifdef EX_SAT_ARITH_EN
    if (e.v) e.alu = (full > 0) ? 16'h7FFF : 16'h8000;
`endif
    sg = a;
    case (m_ctl[3:0])
      4'd2:  begin e.alu = ~(a & b);         e.cls = 1; end
      4'd3:  begin e.alu = a ^ b;            e.cls = 1; end
      4'd5:  begin e.alu = sg >>> b[3:0];    e.cls = 1; end
      4'd6:  begin e.alu = a >> b[3:0];      e.cls = 1; end
      4'd7:  begin e.alu = a << b[3:0];      e.cls = 1; end
      4'd10: begin e.alu = {b[7:0], a[7:0]}; e.cls = 2; end
      4'd11: begin e.alu = {a[15:8], b[7:0]}; e.cls = 2; end
      default: ;
    endcase
    if (e.cls == 1) e.z = (e.alu == 16'h0000);
    e.maddr = m_ctl[7] ? a : e.alu;
    e.sdata = m_ctl[6] ? m_pcinc : b1;
    case (m_bc)
      3'd0: ok = !mz;
      3'd1: ok = mz;
      3'd2: ok = !mz && !mn;
      3'd3: ok = mn;
      3'd4: ok = mz || !mn;
      3'd5: ok = mn || mz;
      3'd6: ok = mv;
      default: ok = 1'b1;
    endcase
    e.taken = m_ctl[9] && ok;
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ctl = 0; m_m = 0; m_wb = 0; m_r0 = 0; m_r1 = 0; m_imm = 0; m_off = 0;
      m_pcinc = 0; m_pcbr = 0; m_s0 = 0; m_s1 = 0; m_bc = 0; m_bub = 0;
      mz = 0; mv = 0; mn = 0;
    end else begin
      pe = calc();
      if (!m_ctl[9] && m_m == 2'b00 && m_wb[2]) begin
        if (pe.cls == 0) begin mz = pe.z; mv = pe.v; mn = pe.n; end
        else if (pe.cls == 1) mz = pe.z;
      end
      m_bub = bubble;
      m_ctl = bubble ? 10'd0 : id_EX;
      m_m   = bubble ? 2'd0 : id_M;
      m_wb  = bubble ? 7'd0 : id_WB;
      m_r0 = id_r0data; m_r1 = id_r1data; m_imm = id_imm; m_off = id_offset;
      m_pcinc = id_PC_inc; m_pcbr = id_PCbranch;
      m_s0 = id_src0; m_s1 = id_src1; m_bc = id_bcond;
    end
  end

  // Per-cycle comparison; datapath outputs of a bubble are don't-care.
  always @(negedge clk) begin
    if (chk_en) begin
      ce = calc();
      if (!m_bub) begin
        chk("cmp_alu_out", alu_out, ce.alu);
        chk("cmp_mem_addr", mem_addr, ce.maddr);
        chk("cmp_store_data", store_data, ce.sdata);
        chk("cmp_branch_target", branch_target, m_pcbr);
      end
      chk("cmp_M_out", {14'd0, M_out}, {14'd0, m_m});
      chk("cmp_WB_out", {9'd0, WB_out}, {9'd0, m_wb});
      chk("cmp_branch_taken", {15'd0, branch_taken}, {15'd0, ce.taken});
      chk("cmp_flags", {13'd0, flags}, {13'd0, mz, mv, mn});
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [9:0] exv(input logic br, sp, pcm, input logic [1:0] src,
                                     input logic [3:0] op);
    return {br, 1'b0, sp, pcm, src, op};
  endfunction

  task automatic clr_in();
    bubble = 0; id_EX = 0; id_M = 0; id_WB = 0;
    id_r0data = 0; id_r1data = 0; id_src0 = 0; id_src1 = 0;
    id_imm = 0; id_offset = 0; id_PC_inc = 0; id_PCbranch = 0; id_bcond = 0;
    fm_we = 0; fm_addr = 0; fm_data = 0; fw_we = 0; fw_addr = 0; fw_data = 0;
  endtask

  task automatic nxt();
    @(negedge clk); #1; clr_in();
  endtask

  task automatic go();
    @(posedge clk); #1;
  endtask

  // register-writing ALU op
  task automatic aluop(input logic [3:0] op, input logic [1:0] src,
                       input logic [3:0] s0, input logic [15:0] r0,
                       input logic [3:0] s1, input logic [15:0] r1,
                       input logic [15:0] imm, input logic [15:0] off,
                       input logic [3:0] dst);
    id_EX = exv(0, 0, 0, src, op); id_M = 2'b00; id_WB = {dst, 3'b100};
    id_src0 = s0; id_r0data = r0; id_src1 = s1; id_r1data = r1;
    id_imm = imm; id_offset = off;
  endtask

  initial begin
    clr_in(); rst = 1;
    go();
    chk("rst_alu_out", alu_out, 16'h0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_store_data", store_data, 16'h0);
    chk("rst_M_out", {14'd0, M_out}, 16'h0);
    chk("rst_WB_out", {9'd0, WB_out}, 16'h0);
    chk("rst_taken", {15'd0, branch_taken}, 16'h0);
    chk("rst_target", branch_target, 16'h0);
    chk("rst_flags", {13'd0, flags}, 16'h0);
    chk_en = 1;

    // ADD 7FFF + 0001
    nxt(); rst = 0; aluop(4'd0, 2'b00, 4'd1, 16'h7FFF, 4'd2, 16'h0001, 0, 0, 4'd3); go();
`ifdef EX_SAT_ARITH_EN
    chk("add_ovf_alu", alu_out, 16'h7FFF);
`else
    chk("add_ovf_alu", alu_out, 16'h8000);
`endif
    // SRA 8000 by imm 4
    nxt(); aluop(4'd5, 2'b01, 4'd1, 16'h8000, 4'd0, 0, 16'h0004, 0, 4'd5); go();
    chk("sra_alu", alu_out, 16'hF800);
    chk("add_flags", {13'd0, flags}, 16'h0003);
    // NAND FFFF, 00FF
    nxt(); aluop(4'd2, 2'b00, 4'd1, 16'hFFFF, 4'd2, 16'h00FF, 0, 0, 4'd5); go();
    chk("nand_alu", alu_out, 16'hFF00);
    chk("sra_flags_hold_vn", {13'd0, flags}, 16'h0003);
    // XOR to zero
    nxt(); aluop(4'd3, 2'b00, 4'd2, 16'h00FF, 4'd3, 16'h00FF, 0, 0, 4'd5); go();
    chk("xor_zero_alu", alu_out, 16'h0000);
    // LHB / LLB
    nxt(); aluop(4'hA, 2'b01, 4'd1, 16'h1234, 4'd0, 0, 16'h00AB, 0, 4'd6); go();
    chk("lhb_alu", alu_out, 16'hAB34);
    chk("xor_z_flags", {13'd0, flags}, 16'h0007);
    nxt(); aluop(4'hB, 2'b10, 4'd1, 16'h1234, 4'd0, 0, 0, 16'hFFCD, 4'd6); go();
    chk("llb_alu", alu_out, 16'h12CD);
    chk("lhb_no_flags", {13'd0, flags}, 16'h0007);

    // SUB r4 = 8 - 3, then forwarding cases
    nxt(); aluop(4'd1, 2'b00, 4'd1, 16'h0008, 4'd2, 16'h0003, 0, 0, 4'd4); go();
    chk("sub_alu", alu_out, 16'h0005);
    nxt(); aluop(4'd3, 2'b00, 4'd4, 16'h1111, 4'd6, 16'h00F0, 0, 0, 4'd5);
    fm_we = 1; fm_addr = 4'd4; fm_data = 16'h0005; go();
    chk("fwd_mem", alu_out, 16'h00F5);
    chk("sub_flags", {13'd0, flags}, 16'h0000);
    nxt(); aluop(4'd3, 2'b00, 4'd4, 16'h1111, 4'd6, 16'h00F0, 0, 0, 4'd5);
    fm_we = 1; fm_addr = 4'd4; fm_data = 16'h0005;
    fw_we = 1; fw_addr = 4'd4; fw_data = 16'h2222; go();
    chk("fwd_mem_beats_wb", alu_out, 16'h00F5);
    nxt(); aluop(4'd3, 2'b00, 4'd0, 16'h1111, 4'd6, 16'h00F0, 0, 0, 4'd5);
    fm_we = 1; fm_addr = 4'd0; fm_data = 16'h0005; go();
    chk("no_fwd_r0", alu_out, 16'h11E1);

    // SUB to zero, then BEQ / BNE
    nxt(); aluop(4'd1, 2'b00, 4'd1, 16'h0009, 4'd2, 16'h0009, 0, 0, 4'd7); go();
    chk("sub_zero_alu", alu_out, 16'h0000);
    nxt(); id_EX = exv(1, 0, 0, 2'b00, 4'd0); id_bcond = 3'b001; id_PCbranch = 16'h0040; go();
    chk("beq_taken", {15'd0, branch_taken}, 16'h0001);
    chk("beq_target", branch_target, 16'h0040);
    chk("sub_zero_flags", {13'd0, flags}, 16'h0004);
    nxt(); aluop(4'd1, 2'b00, 4'd1, 16'h0009, 4'd2, 16'h0009, 0, 0, 4'd7); go();
    nxt(); id_EX = exv(1, 0, 0, 2'b00, 4'd0); id_bcond = 3'b000; id_PCbranch = 16'h0040; go();
    chk("bne_not_taken", {15'd0, branch_taken}, 16'h0000);

    // Call / Ret
    nxt(); id_EX = exv(0, 1, 1, 2'b11, 4'd1); id_M = 2'b10; id_WB = {4'hF, 3'b100};
    id_src0 = 4'hF; id_r0data = 16'h0100; id_PC_inc = 16'h0021; go();
    chk("call_mem_addr", mem_addr, 16'h0100);
    chk("call_store_data", store_data, 16'h0021);
    chk("call_alu", alu_out, 16'h00FF);
    chk("call_M_out", {14'd0, M_out}, 16'h0002);
    chk("call_WB_out", {9'd0, WB_out}, 16'h007C);
    nxt(); id_EX = exv(0, 0, 0, 2'b11, 4'd0); id_M = 2'b01; id_WB = {4'hF, 3'b110};
    id_src0 = 4'hF; id_r0data = 16'h00FF; go();
    chk("ret_mem_addr", mem_addr, 16'h0100);
    chk("ret_alu", alu_out, 16'h0100);
    chk("ret_WB_out", {9'd0, WB_out}, 16'h007E);

    // bubble over an ADD + branch
    nxt(); aluop(4'd0, 2'b00, 4'd1, 16'h7FFF, 4'd2, 16'h0001, 0, 0, 4'd3);
    id_EX[9] = 1'b1; id_bcond = 3'b111; bubble = 1; go();
    chk("bub_WB_out", {9'd0, WB_out}, 16'h0000);
    chk("bub_M_out", {14'd0, M_out}, 16'h0000);
    chk("bub_taken", {15'd0, branch_taken}, 16'h0000);
    chk("bub_flags", {13'd0, flags}, 16'h0004);
    nxt(); go();
    chk("bub_flags_after", {13'd0, flags}, 16'h0004);

    // taken branch in EX while a bubble arrives
    nxt(); id_EX = exv(1, 0, 0, 2'b00, 4'd0); id_bcond = 3'b111; id_PCbranch = 16'h0077; go();
    chk("unc_taken", {15'd0, branch_taken}, 16'h0001);
    chk("unc_target", branch_target, 16'h0077);
    nxt(); aluop(4'd0, 2'b00, 4'd1, 16'h0001, 4'd2, 16'h0001, 0, 0, 4'd3); bubble = 1; #1;
    chk("unc_taken_during_bubble", {15'd0, branch_taken}, 16'h0001);
    go();
    chk("unc_killed_next", {15'd0, branch_taken}, 16'h0000);

    // reset with a taken branch in EX
    nxt(); id_EX = exv(1, 0, 0, 2'b00, 4'd0); id_bcond = 3'b111; id_PCbranch = 16'h0055; go();
    chk("pre_rst_taken", {15'd0, branch_taken}, 16'h0001);
    chk("pre_rst_flags", {13'd0, flags}, 16'h0004);
    nxt(); rst = 1; aluop(4'd0, 2'b00, 4'd1, 16'h1234, 4'd2, 16'h0001, 0, 0, 4'd3); go();
    chk("mid_rst_alu", alu_out, 16'h0);
    chk("mid_rst_mem_addr", mem_addr, 16'h0);
    chk("mid_rst_WB_out", {9'd0, WB_out}, 16'h0);
    chk("mid_rst_M_out", {14'd0, M_out}, 16'h0);
    chk("mid_rst_taken", {15'd0, branch_taken}, 16'h0);
    chk("mid_rst_target", branch_target, 16'h0);
    chk("mid_rst_flags", {13'd0, flags}, 16'h0);
    nxt(); rst = 0; go();
    nxt(); go();
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
